// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit pipeline: NOP opcode, fetch FSM states and
// the instruction-length decode used by fetch, decode and hazard wiring.
package cpu_pkg;

    localparam logic [7:0] NOP_OPC = 8'h00;

    typedef enum logic [0:0] {
        S_OP  = 1'b0,
        S_IMM = 1'b1
    } fetch_state_e;

    // LDM/LDD/STD occupy the 0xC_ row and carry one immediate byte
    function automatic logic is_two_byte(input logic [7:0] op);
        return (op[7:4] == 4'hC);
    endfunction

endpackage

// File: rtl/fetch_stage.sv
// Fetch stage: PC select (RET > branch > immediate > stall > sequential) and the
// IF/ID register that assembles 2-byte instructions into instr_D/imm_D.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 8,
    parameter int unsigned       DATA_W    = 8,
    parameter logic [ADDR_W-1:0] RESET_VEC = 8'h00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_F,
    input  logic              stall_D,
    input  logic              flush_D,
    input  logic              branch_taken_E,
    input  logic [ADDR_W-1:0] branch_target_E,
    input  logic              ret_valid_M,
    input  logic [ADDR_W-1:0] ret_pc_M,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] instr_D,
    output logic [DATA_W-1:0] imm_D,
    output logic [ADDR_W-1:0] pc_plus1_D,
    output logic              valid_D,
    output logic              is_2byte_D
);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_pc_next;
    logic [DATA_W-1:0] r_instr;
    logic [DATA_W-1:0] r_imm;
    logic [ADDR_W-1:0] r_pc_plus1;
    logic              r_valid;
    fetch_state_e      r_state;

    assign w_pc_inc = r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};

    // Next-PC mux; an immediate fetch must advance even while stall_F is low
    always_comb begin
        w_pc_next = r_pc;
        if (ret_valid_M) begin
            w_pc_next = ret_pc_M;
        end else if (branch_taken_E) begin
            w_pc_next = branch_target_E;
        end else if (r_state == S_IMM) begin
            w_pc_next = w_pc_inc;
        end else if (!stall_F) begin
            w_pc_next = r_pc;
        end else begin
            w_pc_next = w_pc_inc;
        end
    end

    // Program counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_VEC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    // IF/ID register and opcode/immediate FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr    <= DATA_W'(NOP_OPC);
            r_imm      <= {DATA_W{1'b0}};
            r_pc_plus1 <= {ADDR_W{1'b0}};
            r_valid    <= 1'b0;
            r_state    <= S_OP;
        end else if (flush_D) begin
            r_instr <= DATA_W'(NOP_OPC);
            r_imm   <= {DATA_W{1'b0}};
            r_valid <= 1'b0;
            r_state <= S_OP;
        end else if (r_state == S_IMM) begin
            r_imm      <= imem_rdata;
            r_pc_plus1 <= w_pc_inc;
            r_state    <= S_OP;
        end else if (!stall_D) begin
            r_state <= r_state;
        end else begin
            r_instr    <= imem_rdata;
            r_imm      <= {DATA_W{1'b0}};
            r_pc_plus1 <= w_pc_inc;
            r_valid    <= 1'b1;
            r_state    <= is_two_byte(imem_rdata) ? S_IMM : S_OP;
        end
    end

    assign imem_addr  = r_pc;
    assign instr_D    = r_instr;
    assign imm_D      = r_imm;
    assign pc_plus1_D = r_pc_plus1;
    assign valid_D    = r_valid;
    assign is_2byte_D = (r_state == S_IMM);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a byte-array instruction memory feeds the DUT and
// each scenario task compares the Decode-side outputs against hand-computed values.
module tb_fetch_stage;

    logic       clk;
    logic       rst_n;
    logic       stall_F;
    logic       stall_D;
    logic       flush_D;
    logic       branch_taken_E;
    logic [7:0] branch_target_E;
    logic       ret_valid_M;
    logic [7:0] ret_pc_M;
    logic [7:0] imem_addr;
    logic [7:0] imem_rdata;
    logic [7:0] instr_D;
    logic [7:0] imm_D;
    logic [7:0] pc_plus1_D;
    logic       valid_D;
    logic       is_2byte_D;

    logic [7:0] mem [0:255];
    int n_tests;
    int n_fail;

    // full view {addr, instr, imm, pc+1, valid, is2}; flush view omits pc+1
    logic [33:0] obs;
    logic [25:0] obs_f;
    assign obs   = {imem_addr, instr_D, imm_D, pc_plus1_D, valid_D, is_2byte_D};
    assign obs_f = {imem_addr, instr_D, imm_D, valid_D, is_2byte_D};
    assign imem_rdata = mem[imem_addr];

    fetch_stage #(.ADDR_W(8), .DATA_W(8), .RESET_VEC(8'h00)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall_F         (stall_F),
        .stall_D         (stall_D),
        .flush_D         (flush_D),
        .branch_taken_E  (branch_taken_E),
        .branch_target_E (branch_target_E),
        .ret_valid_M     (ret_valid_M),
        .ret_pc_M        (ret_pc_M),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .instr_D         (instr_D),
        .imm_D           (imm_D),
        .pc_plus1_D      (pc_plus1_D),
        .valid_D         (valid_D),
        .is_2byte_D      (is_2byte_D)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        if (obs !== {8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0}) begin
            $display("FAIL reset: got %h want %h", obs, {8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0});
            n_fail++;
        end
        n_tests++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_sequential();
        step();
        if (obs !== {8'h01, 8'h11, 8'h00, 8'h01, 1'b1, 1'b0}) begin
            $display("FAIL seq0: got %h want %h", obs, {8'h01, 8'h11, 8'h00, 8'h01, 1'b1, 1'b0});
            n_fail++;
        end
        n_tests++;
        step();
        if (obs !== {8'h02, 8'h22, 8'h00, 8'h02, 1'b1, 1'b0}) begin
            $display("FAIL seq1: got %h want %h", obs, {8'h02, 8'h22, 8'h00, 8'h02, 1'b1, 1'b0});
            n_fail++;
        end
        n_tests++;
        step();
        if (obs !== {8'h03, 8'h33, 8'h00, 8'h03, 1'b1, 1'b0}) begin
            $display("FAIL seq2: got %h want %h", obs, {8'h03, 8'h33, 8'h00, 8'h03, 1'b1, 1'b0});
            n_fail++;
        end
        n_tests++;
    endtask

    task automatic test_two_byte();
        step();
        if (obs !== {8'h04, 8'h44, 8'h00, 8'h04, 1'b1, 1'b0}) begin
            $display("FAIL pre2b: got %h want %h", obs, {8'h04, 8'h44, 8'h00, 8'h04, 1'b1, 1'b0});
            n_fail++;
        end
        n_tests++;
        step();
        if (obs !== {8'h05, 8'hC1, 8'h00, 8'h05, 1'b1, 1'b1}) begin
            $display("FAIL opc2b: got %h want %h", obs, {8'h05, 8'hC1, 8'h00, 8'h05, 1'b1, 1'b1});
            n_fail++;
        end
        n_tests++;
        stall_F = 1'b0;
        stall_D = 1'b0;
        step();
        if (obs !== {8'h06, 8'hC1, 8'h7E, 8'h06, 1'b1, 1'b0}) begin
            $display("FAIL imm2b: got %h want %h", obs, {8'h06, 8'hC1, 8'h7E, 8'h06, 1'b1, 1'b0});
            n_fail++;
        end
        n_tests++;
        stall_F = 1'b1;
        stall_D = 1'b1;
    endtask

    task automatic test_stall();
        branch_taken_E  = 1'b1;
        branch_target_E = 8'h0F;
        flush_D         = 1'b1;
        step();
        branch_taken_E = 1'b0;
        flush_D        = 1'b0;
        step();
        if (obs !== {8'h10, 8'hA0, 8'h00, 8'h10, 1'b1, 1'b0}) begin
            $display("FAIL stall_pre: got %h want %h", obs, {8'h10, 8'hA0, 8'h00, 8'h10, 1'b1, 1'b0});
            n_fail++;
        end
        n_tests++;
        stall_F = 1'b0;
        stall_D = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (obs !== {8'h10, 8'hA0, 8'h00, 8'h10, 1'b1, 1'b0}) begin
                $display("FAIL stall_hold%0d: got %h want %h", i, obs, {8'h10, 8'hA0, 8'h00, 8'h10, 1'b1, 1'b0});
                n_fail++;
            end
            n_tests++;
        end
        stall_F = 1'b1;
        stall_D = 1'b1;
        step();
        if (obs !== {8'h11, 8'hA1, 8'h00, 8'h11, 1'b1, 1'b0}) begin
            $display("FAIL stall_resume: got %h want %h", obs, {8'h11, 8'hA1, 8'h00, 8'h11, 1'b1, 1'b0});
            n_fail++;
        end
        n_tests++;
    endtask

    task automatic test_branch();
        branch_taken_E  = 1'b1;
        branch_target_E = 8'h40;
        flush_D         = 1'b1;
        step();
        branch_taken_E = 1'b0;
        flush_D        = 1'b0;
        if (obs_f !== {8'h40, 8'h00, 8'h00, 1'b0, 1'b0}) begin
            $display("FAIL br_flush: got %h want %h", obs_f, {8'h40, 8'h00, 8'h00, 1'b0, 1'b0});
            n_fail++;
        end
        n_tests++;
        step();
        if (obs !== {8'h41, 8'h5A, 8'h00, 8'h41, 1'b1, 1'b0}) begin
            $display("FAIL br_target: got %h want %h", obs, {8'h41, 8'h5A, 8'h00, 8'h41, 1'b1, 1'b0});
            n_fail++;
        end
        n_tests++;
        step();
        if (obs !== {8'h42, 8'hC2, 8'h00, 8'h42, 1'b1, 1'b1}) begin
            $display("FAIL br_opc2b: got %h want %h", obs, {8'h42, 8'hC2, 8'h00, 8'h42, 1'b1, 1'b1});
            n_fail++;
        end
        n_tests++;
        branch_taken_E  = 1'b1;
        branch_target_E = 8'h50;
        flush_D         = 1'b1;
        step();
        branch_taken_E = 1'b0;
        flush_D        = 1'b0;
        if (obs_f !== {8'h50, 8'h00, 8'h00, 1'b0, 1'b0}) begin
            $display("FAIL br_abort_imm: got %h want %h", obs_f, {8'h50, 8'h00, 8'h00, 1'b0, 1'b0});
            n_fail++;
        end
        n_tests++;
        step();
        if (obs !== {8'h51, 8'h01, 8'h00, 8'h51, 1'b1, 1'b0}) begin
            $display("FAIL br_after_abort: got %h want %h", obs, {8'h51, 8'h01, 8'h00, 8'h51, 1'b1, 1'b0});
            n_fail++;
        end
        n_tests++;
    endtask

    task automatic test_ret_wrap();
        ret_valid_M     = 1'b1;
        ret_pc_M        = 8'hFF;
        branch_taken_E  = 1'b1;
        branch_target_E = 8'h20;
        flush_D         = 1'b1;
        stall_F         = 1'b0;
        step();
        ret_valid_M    = 1'b0;
        branch_taken_E = 1'b0;
        flush_D        = 1'b0;
        stall_F        = 1'b1;
        if (obs_f !== {8'hFF, 8'h00, 8'h00, 1'b0, 1'b0}) begin
            $display("FAIL ret_pc: got %h want %h", obs_f, {8'hFF, 8'h00, 8'h00, 1'b0, 1'b0});
            n_fail++;
        end
        n_tests++;
        step();
        if (obs !== {8'h00, 8'h3C, 8'h00, 8'h00, 1'b1, 1'b0}) begin
            $display("FAIL ret_wrap: got %h want %h", obs, {8'h00, 8'h3C, 8'h00, 8'h00, 1'b1, 1'b0});
            n_fail++;
        end
        n_tests++;
        step();
        if (obs !== {8'h01, 8'h11, 8'h00, 8'h01, 1'b1, 1'b0}) begin
            $display("FAIL ret_after_wrap: got %h want %h", obs, {8'h01, 8'h11, 8'h00, 8'h01, 1'b1, 1'b0});
            n_fail++;
        end
        n_tests++;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h01;
        mem[8'h00] = 8'h11;
        mem[8'h01] = 8'h22;
        mem[8'h02] = 8'h33;
        mem[8'h03] = 8'h44;
        mem[8'h04] = 8'hC1;
        mem[8'h05] = 8'h7E;
        mem[8'h0F] = 8'hA0;
        mem[8'h10] = 8'hA1;
        mem[8'h40] = 8'h5A;
        mem[8'h41] = 8'hC2;
        mem[8'h42] = 8'h99;
        mem[8'hFF] = 8'h3C;

        rst_n           = 1'b0;
        stall_F         = 1'b1;
        stall_D         = 1'b1;
        flush_D         = 1'b0;
        branch_taken_E  = 1'b0;
        branch_target_E = 8'h00;
        ret_valid_M     = 1'b0;
        ret_pc_M        = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        test_reset();
        test_sequential();
        test_two_byte();
        test_stall();
        test_branch();
        test_ret_wrap();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
